in_mem_loader: RTL and testbench
================================

// Module: in_mem_loader
// PURPOSE
//  Upstream feeder of the input-feature memory. Accepts 64-bit beats from the AXI HP
//  DMA stream and converts them into sequential write strobes (wr_en/wr_addr/wr_data)
//  for the input memory wrapper. Software-armed: start + base + beat count -> busy -> done.
//  Flags length mismatches so the controller never launches CONV/MAXPOOL on partial data.
// PARAMETERS
//  AXI_HP_BIT  64  stream beat width = memory word width
//  ADDR_WIDTH  14  memory address is ADDR_WIDTH+1 bits; depth 2^(ADDR_WIDTH+1) words
// PORTS
//  clk        in   1               single clock, all logic rising edge
//  rst        in   1               synchronous, active-high reset
//  start      in   1               arm a transfer (sampled only in IDLE)
//  base_addr  in   ADDR_WIDTH+1    first memory word address
//  num_beats  in   ADDR_WIDTH+2    beats expected; 0 = empty transfer
//  s_tdata    in   AXI_HP_BIT      stream data
//  s_tvalid   in   1               stream valid
//  s_tlast    in   1               stream last beat marker
//  s_tready   out  1               stream ready
//  wr_en      out  1               memory write strobe (registered)
//  wr_addr    out  ADDR_WIDTH+1    memory write address (registered)
//  wr_data    out  AXI_HP_BIT      memory write data (registered)
//  busy       out  1               transfer in progress
//  done       out  1               one-cycle completion pulse
//  err_len    out  1               sticky: tlast position != num_beats
// BEHAVIOUR
//  Reset: state IDLE; s_tready, wr_en, busy, done, err_len = 0; wr_addr, wr_data = 0.
//  Reset mid-transfer abandons it: no further wr_en, partial data left in memory.
//  FSM IDLE -> LOAD -> DONE -> IDLE.
//  IDLE: s_tready=0. start & num_beats!=0: latch base_addr, remaining=num_beats,
//   clear err_len, -> LOAD. start & num_beats==0: clear err_len, -> DONE (no writes).
//  LOAD: s_tready=1, busy=1. Beat accepted iff s_tvalid & s_tready in cycle N ->
//   cycle N+1: wr_en=1, wr_addr=current addr, wr_data=s_tdata. addr += 1 modulo
//   2^(ADDR_WIDTH+1) (wraps to 0, no error); remaining -= 1. No accepted beat -> wr_en=0.
//   Accepted beat with remaining==1: -> DONE; err_len=1 if s_tlast==0.
//   Accepted beat with s_tlast=1 and remaining>1: -> DONE early, err_len=1.
//  DONE: s_tready=0, busy=1, done=1 for exactly one cycle; this is the cycle the final
//   wr_en is presented, so memory holds all data from the cycle after done. -> IDLE.
//  start outside IDLE is ignored. err_len holds until next accepted start.
//  Throughput: one beat per cycle sustained; s_tready never depends on s_tvalid.
//  Loader only issues writes; read arbitration (OPCODE mux) stays in the memory
//  wrapper; controller must not issue reads while busy=1.
// STRUCTURE
//  Shared package: FSM state localparams (IDLE/LOAD/DONE), AXI_HP_BIT, ADDR_WIDTH defaults.
//  Single module, no sub-module; address counter and beat counter inline.
// TESTING
//  1 base=0x0100, num=4, beats D0..D3 back-to-back, tlast on D3 -> wr_en 4 consecutive
//    cycles at 0x0100..0x0103 with D0..D3; done with last wr_en; err_len=0.
//  2 num=3, s_tvalid toggled 1,0,1,0,1 -> exactly 3 writes, addresses contiguous,
//    gaps in wr_en match gaps in s_tvalid; done after 3rd write.
//  3 base=0x7FFE, num=4 -> wr_addr 0x7FFE,0x7FFF,0x0000,0x0001; err_len=0.
//  4 num=4, tlast on beat 2 -> 2 writes, done, err_len=1; next start with good
//    stream clears err_len. num=2, no tlast -> 2 writes, done, err_len=1.
//  5 start with num=0 -> no wr_en, done 1 cycle later, s_tready stays 0.
//  6 rst asserted after 2 of 8 beats -> next cycle all outputs 0, state IDLE,
//    s_tready=0; start pulse during LOAD ignored (no re-latch of base_addr).

Source files
------------

// File: rtl/in_mem_loader_pkg.sv
// Shared definitions for the input-memory loader: default widths and FSM states.
package in_mem_loader_pkg;

    // Stream beat width, equal to the input-memory word width.
    localparam int DEF_AXI_HP_BIT = 64;
    // Memory address is DEF_ADDR_WIDTH+1 bits wide.
    localparam int DEF_ADDR_WIDTH = 14;

    // Loader sequencing: wait for arm, stream beats into memory, pulse completion.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : in_mem_loader_pkg

// File: rtl/in_mem_loader_if.sv
// AXI-Stream style beat channel from the HP DMA into the input-memory loader.
interface in_mem_loader_if
    import in_mem_loader_pkg::*;
#(
    parameter int AXI_HP_BIT = DEF_AXI_HP_BIT
);

    logic [AXI_HP_BIT-1:0] s_tdata;
    logic                  s_tvalid;
    logic                  s_tlast;
    logic                  s_tready;

    // Stream source (DMA side).
    modport master (
        output s_tdata,
        output s_tvalid,
        output s_tlast,
        input  s_tready
    );

    // Stream sink (loader side).
    modport slave (
        input  s_tdata,
        input  s_tvalid,
        input  s_tlast,
        output s_tready
    );

endinterface : in_mem_loader_if

// File: rtl/in_mem_loader.sv
// Converts a software-armed run of stream beats into sequential input-memory writes,
// flagging when the stream's tlast position disagrees with the armed beat count.
module in_mem_loader
    import in_mem_loader_pkg::*;
#(
    parameter int AXI_HP_BIT = DEF_AXI_HP_BIT,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   base_addr,
    input  logic [ADDR_WIDTH+1:0] num_beats,
    in_mem_loader_if.slave        s,
    output logic                  wr_en,
    output logic [ADDR_WIDTH:0]   wr_addr,
    output logic [AXI_HP_BIT-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err_len
);

    localparam int REM_W = ADDR_WIDTH + 2;

    state_t            state;
    logic [ADDR_WIDTH:0] addr;       // next memory word to write, wraps modulo depth
    logic [REM_W-1:0]    remaining;  // beats still expected in this transfer
    logic                beat_ok;
    logic                last_beat;

    // A beat moves only on a valid/ready handshake; ready is a pure function of state.
    assign beat_ok   = s.s_tvalid & s.s_tready;
    assign last_beat = (remaining == REM_W'(1));

    // Single FSM: sequencing, counters and every registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            addr       <= '0;
            remaining  <= '0;
            s.s_tready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_len    <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each cycle; non-blocking assignments let
            // the case below override them without ordering hazards between outputs.
            wr_en <= 1'b0;
            done  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        err_len <= 1'b0;
                        busy    <= 1'b1;
                        if (num_beats != '0) begin
                            addr       <= base_addr;
                            remaining  <= num_beats;
                            s.s_tready <= 1'b1;
                            state      <= ST_LOAD;
                        end else begin
                            // Empty transfer: complete immediately without writes.
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end

                ST_LOAD: begin
                    if (beat_ok) begin
                        wr_en     <= 1'b1;
                        wr_addr   <= addr;
                        wr_data   <= s.s_tdata;
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (last_beat || s.s_tlast) begin
                            // Clean end only when tlast lands exactly on the final beat.
                            err_len    <= ~last_beat | ~s.s_tlast;
                            s.s_tready <= 1'b0;
                            done       <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    s.s_tready <= 1'b0;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : in_mem_loader

// File: tb/tb_in_mem_loader.sv
// Self-checking bench for in_mem_loader: directed vector table, reset corner
// sequences and randomized transfers scored against a transfer-level model.
module tb_in_mem_loader;
    import in_mem_loader_pkg::*;

    localparam int DW = 64;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   base_addr;
    logic [AW+1:0] num_beats;
    logic          wr_en;
    logic [AW:0]   wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          err_len;

    int total = 0;
    int bad   = 0;

    in_mem_loader_if #(.AXI_HP_BIT(DW)) s_if ();

    in_mem_loader #(.AXI_HP_BIT(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_beats (num_beats),
        .s         (s_if),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err_len   (err_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Transfer-level reference: how many beats get written and whether the length flag sets.
    function automatic void ref_model(input int num, input int tlast_at, output int k, output bit err);
        if (num == 0) begin
            k = 0; err = 1'b0;
        end else if (tlast_at >= 0 && tlast_at < num) begin
            k = tlast_at + 1; err = (tlast_at != num - 1);
        end else begin
            k = num; err = 1'b1;
        end
    endfunction

    // Runs one armed transfer. Called right after a falling edge; returns right after one.
    // gap_mode: 0 back-to-back, 1 valid alternates 1,0,1,..., 2 random valid.
    task automatic run_xfer(input string tag, input logic [AW:0] base, input logic [AW+1:0] num,
                            input int tlast_at, input int gap_mode, input bit poke_start,
                            input int exp_k, input bit exp_err);
        logic [DW-1:0] beats[$];
        int  acc, pidx, ready_cycles, dut_writes;
        bit  fin, pend, pend_final, first, finished, exp_done;
        bit  v;
        acc = 0; pidx = 0; ready_cycles = 0; dut_writes = 0;
        fin = (num == 0); pend = 0; pend_final = 0; first = 1; finished = 0;

        start = 1'b1; base_addr = base; num_beats = num;
        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            exp_done = pend_final || (num == 0 && first);
            if (wr_en) dut_writes++;
            check({tag, " wr_en"}, wr_en, pend);
            if (pend) begin
                check({tag, " wr_addr"}, wr_addr, (AW+1)'(base + pidx));
                check({tag, " wr_data"}, wr_data, beats[pidx]);
            end
            check({tag, " done"}, done, exp_done);
            check({tag, " busy"}, busy, 1'b1);
            check({tag, " s_tready"}, s_if.s_tready, !fin);
            check({tag, " err_len"}, err_len, exp_done ? exp_err : 1'b0);

            if (exp_done) begin
                // Junk beat and a stray start during DONE must both be ignored.
                s_if.s_tvalid = 1'b1;
                s_if.s_tdata  = {$urandom, $urandom};
                s_if.s_tlast  = 1'($urandom_range(0, 1));
                start = poke_start;
                @(negedge clk);
                start = 1'b0;
                s_if.s_tvalid = 1'b0;
                check({tag, " idle wr_en"}, wr_en, 1'b0);
                check({tag, " idle busy"}, busy, 1'b0);
                check({tag, " idle done"}, done, 1'b0);
                check({tag, " idle s_tready"}, s_if.s_tready, 1'b0);
                check({tag, " sticky err_len"}, err_len, exp_err);
                check({tag, " write count"}, dut_writes, exp_k);
                finished = 1;
            end else begin
                case (gap_mode)
                    0:       v = 1'b1;
                    1:       v = (ready_cycles % 2 == 0);
                    default: v = 1'($urandom_range(0, 1));
                endcase
                ready_cycles++;
                if (v) begin
                    beats.push_back({$urandom, $urandom});
                    s_if.s_tvalid = 1'b1;
                    s_if.s_tdata  = beats[acc];
                    s_if.s_tlast  = (acc == tlast_at);
                    pend = 1; pidx = acc; acc++;
                    pend_final = (acc == exp_k);
                    if (pend_final) fin = 1;
                end else begin
                    s_if.s_tvalid = 1'b0;
                    s_if.s_tdata  = {$urandom, $urandom};
                    s_if.s_tlast  = 1'($urandom_range(0, 1));
                    pend = 0; pend_final = 0;
                end
                if (poke_start) begin
                    start     = 1'b1;
                    base_addr = (AW+1)'($urandom);
                    num_beats = (AW+2)'($urandom_range(1, 20));
                end
            end
            first = 0;
        end
        if (!finished) check({tag, " timeout"}, 1'b0, 1'b1);
    endtask

    typedef struct {
        logic [AW:0]   base;
        logic [AW+1:0] num;
        int            tlast_at;
        int            gap_mode;
        bit            poke;
        int            exp_writes;
        bit            exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int  k;
        bit  e;
        int  tl;
        logic [AW:0]   rb;
        logic [AW+1:0] rn;

        rst = 1'b1; start = 1'b0; base_addr = '0; num_beats = '0;
        s_if.s_tvalid = 1'b0; s_if.s_tdata = '0; s_if.s_tlast = 1'b0;
        repeat (3) @(negedge clk);
        check("rst s_tready", s_if.s_tready, 1'b0);
        check("rst wr_en", wr_en, 1'b0);
        check("rst wr_addr", wr_addr, '0);
        check("rst wr_data", wr_data, '0);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst err_len", err_len, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        //           base       num  tlast gap poke writes err
        vecs[0] = '{15'h0100, 16'd4, 3,  0, 0, 4, 1'b0};  // back-to-back, clean
        vecs[1] = '{15'h0200, 16'd3, 2,  1, 0, 3, 1'b0};  // valid gaps
        vecs[2] = '{15'h7FFE, 16'd4, 3,  0, 0, 4, 1'b0};  // address wrap
        vecs[3] = '{15'h0300, 16'd4, 1,  0, 0, 2, 1'b1};  // early tlast
        vecs[4] = '{15'h0400, 16'd4, 3,  0, 0, 4, 1'b0};  // good stream clears err_len
        vecs[5] = '{15'h0500, 16'd2, -1, 0, 0, 2, 1'b1};  // missing tlast
        vecs[6] = '{15'h0600, 16'd0, -1, 0, 0, 0, 1'b0};  // empty transfer
        vecs[7] = '{15'h2000, 16'd3, 2,  0, 1, 3, 1'b0};  // start during LOAD ignored

        for (int i = 0; i < 8; i++) begin
            run_xfer($sformatf("vec%0d", i), vecs[i].base, vecs[i].num, vecs[i].tlast_at,
                     vecs[i].gap_mode, vecs[i].poke, vecs[i].exp_writes, vecs[i].exp_err);
            @(negedge clk);
        end

        // Reset clears a sticky err_len left by a mismatched transfer.
        run_xfer("pre_rst", 15'h0010, 16'd2, -1, 0, 0, 2, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst clears err_len", err_len, 1'b0);

        // Reset mid-transfer abandons it.
        start = 1'b1; base_addr = 15'h1000; num_beats = 16'd8;
        @(negedge clk);
        start = 1'b0;
        s_if.s_tvalid = 1'b1; s_if.s_tdata = 64'hAAAA_0000_0000_0000; s_if.s_tlast = 1'b0;
        @(negedge clk);
        check("mid wr_en beat0", wr_en, 1'b1);
        check("mid wr_addr beat0", wr_addr, 15'h1000);
        s_if.s_tdata = 64'hAAAA_0000_0000_0001;
        @(negedge clk);
        check("mid wr_addr beat1", wr_addr, 15'h1001);
        check("mid wr_data beat1", wr_data, 64'hAAAA_0000_0000_0001);
        rst = 1'b1;
        s_if.s_tdata = 64'hAAAA_0000_0000_0002;
        @(negedge clk);
        rst = 1'b0;
        check("abort s_tready", s_if.s_tready, 1'b0);
        check("abort wr_en", wr_en, 1'b0);
        check("abort wr_addr", wr_addr, '0);
        check("abort wr_data", wr_data, '0);
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("post-abort wr_en", wr_en, 1'b0);
            check("post-abort s_tready", s_if.s_tready, 1'b0);
            check("post-abort busy", busy, 1'b0);
        end
        s_if.s_tvalid = 1'b0;
        @(negedge clk);

        // Randomized transfers against the transfer-level model.
        for (int t = 0; t < 40; t++) begin
            rn = (AW+2)'($urandom_range(0, 10));
            rb = ($urandom_range(0, 3) == 0) ? 15'h7FF8 + 15'($urandom_range(0, 7))
                                             : (AW+1)'($urandom);
            case ($urandom_range(0, 3))
                0, 3:    tl = int'(rn) - 1;
                1:       tl = -1;
                default: tl = $urandom_range(0, int'(rn) + 1);
            endcase
            ref_model(int'(rn), tl, k, e);
            run_xfer($sformatf("rnd%0d", t), rb, rn, tl, 2, 1'($urandom_range(0, 1)), k, e);
            repeat ($urandom_range(0, 2)) begin
                s_if.s_tvalid = 1'($urandom_range(0, 1));
                @(negedge clk);
                check("rnd idle wr_en", wr_en, 1'b0);
            end
            s_if.s_tvalid = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_in_mem_loader
